// File: rtl/boruss_cpu_core.sv
// Boruss CPU core: multi-cycle fetch/execute machine with a parametrised register file,
// registered Z/C/N flags and req/ack instruction and data ports that tolerate wait states.
module boruss_cpu_core #(
  parameter int  DATA_W    = 8,
  parameter int  REG_COUNT = 4,
  localparam int RSEL_W    = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [7:0]        imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [7:0]        dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [7:0]        pc,
  output logic [2:0]        cpu_state,
  output logic [2:0]        flags,
  output logic              halted,
  output logic [7:0]        led_out,
  input  logic [RSEL_W-1:0] debug_sel,
  output logic [DATA_W-1:0] debug_data
);

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_LD  = 4'h9;
  localparam logic [3:0] OP_ST  = 4'hA;
  localparam logic [3:0] OP_JMP = 4'hB;
  localparam logic [3:0] OP_JZ  = 4'hC;
  localparam logic [3:0] OP_JNZ = 4'hD;
  localparam logic [3:0] OP_JC  = 4'hE;
  localparam logic [3:0] OP_CMP = 4'hF;

  state_t            r_state;
  logic [7:0]        r_pc;
  logic [15:0]       r_ir;
  logic [2:0]        r_flags;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_regs [REG_COUNT];

  logic [3:0]        w_op;
  logic [RSEL_W-1:0] w_rd;
  logic [RSEL_W-1:0] w_rs;
  logic [7:0]        w_imm8;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_rd_val;
  logic [DATA_W-1:0] w_rs_val;
  logic              w_is_hlt;
  logic              w_jump_taken;
  logic              w_unused_ir;

  assign w_op        = r_ir[15:12];
  assign w_rd        = r_ir[8 +: RSEL_W];
  assign w_rs        = r_ir[4 +: RSEL_W];
  assign w_imm8      = r_ir[7:0];
  assign w_imm       = DATA_W'(w_imm8);
  assign w_rd_val    = r_regs[w_rd];
  assign w_rs_val    = r_regs[w_rs];
  assign w_is_hlt    = (w_op == OP_CMP) && (r_ir[3:0] == 4'hF);
  assign w_unused_ir = ^r_ir;

  // ALU: CMP shares the subtract path; the extra top bit carries C for every op.
  logic [2:0]        w_alu_sel;
  logic [DATA_W:0]   w_alu_wide;
  logic [DATA_W-1:0] w_alu_res;
  logic              w_alu_c;
  logic              w_alu_z;
  logic              w_alu_n;

  assign w_alu_sel = (w_op == OP_CMP) ? 3'd1 : w_op[2:0];

  // NOTE: every combinational output gets a default before the case, so no path can infer a latch.
  always_comb begin
    w_alu_wide = '0;
    case (w_alu_sel)
      3'd0: w_alu_wide = {1'b0, w_rd_val} + {1'b0, w_rs_val};
      3'd1: w_alu_wide = {1'b0, w_rd_val} - {1'b0, w_rs_val};
      3'd2: w_alu_wide = {1'b0, w_rd_val & w_rs_val};
      3'd3: w_alu_wide = {1'b0, w_rd_val | w_rs_val};
      3'd4: w_alu_wide = {1'b0, w_rd_val ^ w_rs_val};
      3'd5: w_alu_wide = {1'b0, ~w_rs_val};
      3'd6: w_alu_wide = {w_rs_val, 1'b0};
      3'd7: w_alu_wide = {w_rs_val[0], 1'b0, w_rs_val[DATA_W-1:1]};
      default: w_alu_wide = '0;
    endcase
  end

  assign w_alu_res = w_alu_wide[DATA_W-1:0];
  assign w_alu_c   = w_alu_wide[DATA_W];
  assign w_alu_z   = (w_alu_res == '0);
  assign w_alu_n   = w_alu_res[DATA_W-1];

  always_comb begin
    w_jump_taken = 1'b0;
    case (w_op)
      OP_JMP:  w_jump_taken = 1'b1;
      OP_JZ:   w_jump_taken = r_flags[0];
      OP_JNZ:  w_jump_taken = ~r_flags[0];
      OP_JC:   w_jump_taken = r_flags[1];
      default: w_jump_taken = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_BOOT;
      r_pc    <= '0;
      r_ir    <= '0;
      r_flags <= '0;
      r_wdata <= '0;
      // NOTE: the register file is architecturally cleared by reset, so it is built from flops, not RAM.
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        ST_BOOT: r_state <= ST_FETCH;
        ST_FETCH: begin
          if (imem_ack) begin
            r_ir    <= imem_rdata;
            r_pc    <= r_pc + 8'd1;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_state <= ST_FETCH;
          if (!w_op[3]) begin
            r_regs[w_rd] <= w_alu_res;
            r_flags      <= {w_alu_n, w_alu_c, w_alu_z};
          end else begin
            case (w_op)
              OP_LDI: r_regs[w_rd] <= w_imm;
              OP_LD, OP_ST: begin
                r_wdata <= w_rd_val;
                r_state <= ST_MEM;
              end
              OP_JMP, OP_JZ, OP_JNZ, OP_JC: begin
                if (w_jump_taken) r_pc <= w_imm8;
              end
              default: begin
                if (w_is_hlt) r_state <= ST_HALT;
                else          r_flags <= {w_alu_n, w_alu_c, w_alu_z};
              end
            endcase
          end
        end
        ST_MEM: begin
          if (dmem_ack) begin
            if (w_op == OP_LD) r_regs[w_rd] <= dmem_rdata;
            r_state <= ST_FETCH;
          end
        end
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_BOOT;
      endcase
    end
  end

  // Requests are decoded from state so an asynchronous reset withdraws them immediately.
  assign imem_req   = (r_state == ST_FETCH);
  assign imem_addr  = r_pc;
  assign dmem_req   = (r_state == ST_MEM);
  assign dmem_we    = dmem_req && (w_op == OP_ST);
  assign dmem_addr  = w_imm8;
  assign dmem_wdata = r_wdata;
  assign pc         = r_pc;
  assign cpu_state  = r_state;
  assign flags      = r_flags;
  assign halted     = (r_state == ST_HALT);
  assign led_out    = 8'(r_regs[0]);
  assign debug_data = r_regs[debug_sel];

endmodule
